// File: rtl/enc_defines.sv
// Shared encodings for the SATD cost path: block size codes and transpose bank state/mode.
package enc_defines;

  localparam logic [1:0] SIZE_04 = 2'd0;
  localparam logic [1:0] SIZE_08 = 2'd1;
  localparam logic [1:0] SIZE_16 = 2'd2;
  localparam logic [1:0] SIZE_32 = 2'd3;

  typedef enum logic [1:0] {
    StEmpty    = 2'd0,
    StFilling  = 2'd1,
    StFull     = 2'd2,
    StDraining = 2'd3
  } bank_state_e;

  typedef enum logic {
    ModeBlk = 1'b0,
    Mode4   = 1'b1
  } bank_mode_e;

endpackage

// File: rtl/posi_satd_transpose_bank.sv
// One tile of storage: beats are written in arrival order, read back transposed per bank mode.
module posi_satd_transpose_bank
  import enc_defines::*;
#(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned BLK        = 8,
  parameter int unsigned LANES      = 16,
  parameter int unsigned BEATS      = BLK * BLK / LANES,
  parameter int unsigned CW         = $clog2(BEATS)
) (
  input  logic                        clk,
  input  logic                        i_we,
  input  logic [CW-1:0]               i_waddr,
  input  logic [DATA_WIDTH*LANES-1:0] i_wdat,
  input  bank_mode_e                  i_mode,
  input  logic [CW-1:0]               i_raddr,
  output logic [DATA_WIDTH*LANES-1:0] o_rdat
);

  localparam int unsigned ROWS = LANES / BLK;
  localparam int unsigned DW   = DATA_WIDTH;

  logic [BEATS-1:0][DW*LANES-1:0] r_mem;
  logic [BEATS-1:0][DW*LANES-1:0] w_blk;
  logic [BEATS-1:0][DW*LANES-1:0] w_m4;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdat;
  end

  // Sample s of the tile lives in beat s/LANES, lane s%LANES (lane 0 in the MSBs).
  for (genvar gr = 0; gr < BEATS; gr++) begin : g_beat
    for (genvar gp = 0; gp < LANES; gp++) begin : g_lane
      localparam int unsigned SB = (gp % BLK) * BLK + gr * ROWS + gp / BLK;
      localparam int unsigned S4 = gr * LANES + (gp % 4) * 4 + gp / 4;
      assign w_blk[gr][(LANES-1-gp)*DW +: DW] = r_mem[SB / LANES][(LANES-1-SB%LANES)*DW +: DW];
      assign w_m4[gr][(LANES-1-gp)*DW +: DW]  = r_mem[S4 / LANES][(LANES-1-S4%LANES)*DW +: DW];
    end
  end

  assign o_rdat = (i_mode == Mode4) ? w_m4[i_raddr] : w_blk[i_raddr];

endmodule

// File: rtl/posi_satd_transpose_pp.sv
// Ping-pong transpose between Hadamard stages: one bank fills row-major while the other drains
// column-major through a registered valid/ready output.
module posi_satd_transpose_pp
  import enc_defines::*;
#(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned BLK        = 8,
  parameter int unsigned LANES      = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [1:0]                  size_i,
  input  logic                        val_i,
  output logic                        rdy_o,
  input  logic [DATA_WIDTH*LANES-1:0] dat_i,
  output logic                        val_o,
  input  logic                        rdy_i,
  output logic [1:0]                  size_o,
  output logic                        last_o,
  output logic [DATA_WIDTH*LANES-1:0] dat_o
);

  localparam int unsigned BEATS = BLK * BLK / LANES;
  localparam int unsigned CW    = $clog2(BEATS);
  localparam int unsigned BW    = DATA_WIDTH * LANES;

  bank_state_e       r_state [2];
  bank_state_e       w_state_d [2];
  bank_mode_e        r_mode [2];
  bank_mode_e        w_mode_d [2];
  logic [1:0]        r_size [2];
  logic [1:0]        w_size_d [2];
  logic              r_wr_bank, w_wr_bank_d;
  logic              r_rd_bank, w_rd_bank_d;
  logic [CW-1:0]     r_wcnt, w_wcnt_d;
  logic [CW-1:0]     r_rcnt, w_rcnt_d;
  logic              r_val_o, r_last_o;
  logic [1:0]        r_size_o;
  logic [BW-1:0]     r_dat_o;
  logic [BW-1:0]     w_rdat [2];
  bank_state_e       w_wr_st, w_rd_st;
  logic              w_wr_fire, w_load, w_wr_last, w_rd_last;

  assign w_wr_st   = r_state[r_wr_bank];
  assign w_rd_st   = r_state[r_rd_bank];
  assign rdy_o     = (w_wr_st == StEmpty) || (w_wr_st == StFilling);
  assign w_wr_fire = val_i && rdy_o;
  assign w_load    = (!r_val_o || rdy_i) && ((w_rd_st == StFull) || (w_rd_st == StDraining));
  assign w_wr_last = (r_wcnt == CW'(BEATS - 1));
  assign w_rd_last = (r_rcnt == CW'(BEATS - 1));

  // Writer and reader never own the same bank, so their updates cannot collide.
  always_comb begin
    w_state_d   = r_state;
    w_mode_d    = r_mode;
    w_size_d    = r_size;
    w_wr_bank_d = r_wr_bank;
    w_rd_bank_d = r_rd_bank;
    w_wcnt_d    = r_wcnt;
    w_rcnt_d    = r_rcnt;
    if (w_wr_fire) begin
      if (w_wr_st == StEmpty) begin
        w_state_d[r_wr_bank] = StFilling;
        w_mode_d[r_wr_bank]  = (size_i == SIZE_04) ? Mode4 : ModeBlk;
        w_size_d[r_wr_bank]  = size_i;
      end
      if (w_wr_last) begin
        w_state_d[r_wr_bank] = StFull;
        w_wr_bank_d          = ~r_wr_bank;
        w_wcnt_d             = '0;
      end else begin
        w_wcnt_d = r_wcnt + 1'b1;
      end
    end
    if (w_load) begin
      if (w_rd_last) begin
        w_state_d[r_rd_bank] = StEmpty;
        w_rd_bank_d          = ~r_rd_bank;
        w_rcnt_d             = '0;
      end else begin
        w_state_d[r_rd_bank] = StDraining;
        w_rcnt_d             = r_rcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state[0] <= StEmpty;
      r_state[1] <= StEmpty;
      r_mode[0]  <= ModeBlk;
      r_mode[1]  <= ModeBlk;
      r_size[0]  <= '0;
      r_size[1]  <= '0;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wcnt     <= '0;
      r_rcnt     <= '0;
    end else begin
      r_state   <= w_state_d;
      r_mode    <= w_mode_d;
      r_size    <= w_size_d;
      r_wr_bank <= w_wr_bank_d;
      r_rd_bank <= w_rd_bank_d;
      r_wcnt    <= w_wcnt_d;
      r_rcnt    <= w_rcnt_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    posi_satd_transpose_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .BLK       (BLK),
      .LANES     (LANES)
    ) u_bank (
      .clk    (clk),
      .i_we   (w_wr_fire && (r_wr_bank == 1'(gi))),
      .i_waddr(r_wcnt),
      .i_wdat (dat_i),
      .i_mode (r_mode[gi]),
      .i_raddr(r_rcnt),
      .o_rdat (w_rdat[gi])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_val_o  <= 1'b0;
      r_last_o <= 1'b0;
      r_size_o <= '0;
      r_dat_o  <= '0;
    end else if (w_load) begin
      r_val_o  <= 1'b1;
      r_last_o <= w_rd_last;
      r_size_o <= r_size[r_rd_bank];
      r_dat_o  <= w_rdat[r_rd_bank];
    end else if (rdy_i) begin
      r_val_o <= 1'b0;
    end
  end

  assign val_o  = r_val_o;
  assign last_o = r_last_o;
  assign size_o = r_size_o;
  assign dat_o  = r_dat_o;

endmodule

// File: tb/tb_posi_satd_transpose_pp.sv
// Scoreboard bench for the ping-pong transpose; drives a BLK=8 and a BLK=16 instance in turn.
module tb_posi_satd_transpose_pp;
  import enc_defines::*;

  localparam int unsigned DW    = 9;
  localparam int unsigned LANES = 16;
  localparam int unsigned BW    = DW * LANES;

  typedef struct packed {
    logic [BW-1:0] dat;
    logic          last;
    logic [1:0]    size;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          sel = 1'b0;
  logic [1:0]    size_i = 2'd0;
  logic          val_i = 1'b0;
  logic [BW-1:0] dat_i = '0;
  logic          rdy_i = 1'b1;

  logic          rdy8, rdy16, val8, val16, last8, last16;
  logic [1:0]    size8, size16;
  logic [BW-1:0] dat8, dat16;
  logic          w_rdy_o, w_val_o, w_last_o;
  logic [1:0]    w_size_o;
  logic [BW-1:0] w_dat_o;

  exp_t          exp_q[$];
  int unsigned   tile_s [256];
  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;
  int unsigned   n_stall = 0;
  int            cyc = 0;
  int            first_cyc = -1;
  int            last_cyc = -1;
  int unsigned   n_pop = 0;

  always #5 clk = ~clk;

  assign w_rdy_o  = sel ? rdy16  : rdy8;
  assign w_val_o  = sel ? val16  : val8;
  assign w_last_o = sel ? last16 : last8;
  assign w_size_o = sel ? size16 : size8;
  assign w_dat_o  = sel ? dat16  : dat8;

  posi_satd_transpose_pp #(.DATA_WIDTH(DW), .BLK(8), .LANES(LANES)) u_dut8 (
    .clk(clk), .rstn(rstn), .size_i(size_i), .val_i(val_i && !sel), .rdy_o(rdy8),
    .dat_i(dat_i), .val_o(val8), .rdy_i(rdy_i || sel), .size_o(size8), .last_o(last8),
    .dat_o(dat8)
  );

  posi_satd_transpose_pp #(.DATA_WIDTH(DW), .BLK(16), .LANES(LANES)) u_dut16 (
    .clk(clk), .rstn(rstn), .size_i(size_i), .val_i(val_i && sel), .rdy_o(rdy16),
    .dat_i(dat_i), .val_o(val16), .rdy_i(rdy_i || !sel), .size_o(size16), .last_o(last16),
    .dat_o(dat16)
  );

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected output beat r built from the matrix view of the tile held in tile_s.
  function automatic logic [BW-1:0] exp_beat(input int blk, input bit m4, input int r);
    logic [BW-1:0] b;
    int rows, row, col;
    b = '0;
    rows = LANES / blk;
    if (m4) begin
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++)
          b = {b[BW-DW-1:0], DW'(tile_s[r*16 + k*4 + c])};
    end else begin
      for (int ci = 0; ci < rows; ci++)
        for (int k = 0; k < blk; k++) begin
          row = k;
          col = r * rows + ci;
          b = {b[BW-DW-1:0], DW'(tile_s[(row/rows)*16 + (row%rows)*blk + col])};
        end
    end
    return b;
  endfunction

  task automatic send_tile(input int blk, input logic [1:0] sz, input int base, input int mult,
                           input bit toggle, input int nbeats);
    int beats, guard;
    logic [BW-1:0] b;
    beats = blk * blk / LANES;
    for (int i = 0; i < blk * blk; i++) tile_s[i] = (base + i * mult) % 512;
    for (int w = 0; w < nbeats; w++) begin
      b = '0;
      for (int j = 0; j < LANES; j++) b = {b[BW-DW-1:0], DW'(tile_s[w*LANES + j])};
      @(negedge clk);
      val_i  = 1'b1;
      dat_i  = b;
      size_i = (toggle && w > 0) ? 2'(w) : sz;
      guard  = 0;
      while (!w_rdy_o && guard < 200) begin
        n_stall++;
        guard++;
        @(negedge clk);
      end
      if (guard >= 200) check_eq("rdy_timeout", 1, 0);
    end
    if (nbeats == beats)
      for (int r = 0; r < beats; r++)
        exp_q.push_back('{dat: exp_beat(blk, sz == SIZE_04, r), last: (r == beats - 1), size: sz});
  endtask

  task automatic idle();
    @(negedge clk);
    val_i = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || w_val_o) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) check_eq("drain_timeout", 1, 0);
  endtask

  task automatic latency_check();
    idle();
    check_eq("lat_early", BW'(w_val_o), 0);
    @(negedge clk);
    check_eq("lat_first", BW'(w_val_o), 1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: pops on each accepted beat, checks hold-stability under backpressure.
  initial begin
    exp_t          e;
    logic          hold;
    logic [BW-1:0] hdat;
    logic [2:0]    hctl;
    hold = 1'b0;
    hdat = '0;
    hctl = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check_eq("hold_dat", w_dat_o, hdat);
          check_eq("hold_ctl", BW'({w_last_o, w_size_o}), BW'(hctl));
        end
        if (w_val_o && rdy_i) begin
          n_pop++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          if (exp_q.size() == 0) begin
            check_eq("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq("dat", w_dat_o, e.dat);
            check_eq("last", BW'(w_last_o), BW'(e.last));
            check_eq("size", BW'(w_size_o), BW'(e.size));
          end
        end
        hold = w_val_o && !rdy_i;
        hdat = w_dat_o;
        hctl = {w_last_o, w_size_o};
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic stream3(input int blk);
    n_stall = 0;
    first_cyc = -1;
    n_pop = 0;
    send_tile(blk, SIZE_08, 100, 3, 1'b0, blk * blk / LANES);
    send_tile(blk, SIZE_16, 200, 5, 1'b0, blk * blk / LANES);
    send_tile(blk, SIZE_32, 300, 7, 1'b0, blk * blk / LANES);
    idle();
    wait_drain();
    check_eq("stream_stall", BW'(n_stall), 0);
    check_eq("stream_count", BW'(n_pop), BW'(3 * blk * blk / LANES));
    check_eq("stream_contig", BW'(last_cyc - first_cyc), BW'(3 * blk * blk / LANES - 1));
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_val_o", BW'(w_val_o), 0);
    check_eq("rst_last_o", BW'(w_last_o), 0);
    check_eq("rst_size_o", BW'(w_size_o), 0);
    check_eq("rst_dat_o", w_dat_o, 0);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("rst_rdy_o", BW'(w_rdy_o), 1);

    // Single MBLK tile, sample(r,c) = r*8+c
    send_tile(8, SIZE_08, 0, 1, 1'b0, 4);
    latency_check();
    wait_drain();

    // Packed 4x4 blocks
    send_tile(8, SIZE_04, 0, 1, 1'b0, 4);
    idle();
    wait_drain();

    stream3(8);

    // Backpressure during first drain
    n_stall = 0;
    fork
      begin
        send_tile(8, SIZE_08, 11, 13, 1'b0, 4);
        send_tile(8, SIZE_04, 22, 17, 1'b0, 4);
        send_tile(8, SIZE_16, 33, 19, 1'b0, 4);
        idle();
      end
      begin
        int guard;
        guard = 0;
        while (!w_val_o && guard < 50) begin
          @(negedge clk);
          guard++;
        end
        if (guard >= 50) check_eq("bp_wait_timeout", 1, 0);
        @(posedge clk);
        #1 rdy_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy_i = 1'b1;
      end
    join
    wait_drain();
    check_eq("bp_writer_stalled", BW'(n_stall > 0), 1);

    // Mode switch; second tile toggles size_i after its first beat
    send_tile(8, SIZE_08, 50, 5, 1'b0, 4);
    send_tile(8, SIZE_04, 60, 7, 1'b1, 4);
    idle();
    wait_drain();

    // Reset with a held output beat and a partial tile in flight
    @(posedge clk);
    #1 rdy_i = 1'b0;
    send_tile(8, SIZE_16, 7, 11, 1'b0, 4);
    send_tile(8, SIZE_08, 3, 1, 1'b0, 2);
    idle();
    check_eq("pre_rst_val_o", BW'(w_val_o), 1);
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_val_o", BW'(w_val_o), 0);
    check_eq("mid_rst_dat_o", w_dat_o, 0);
    check_eq("mid_rst_rdy_o", BW'(w_rdy_o), 1);
    exp_q.delete();
    rdy_i = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    send_tile(8, SIZE_08, 0, 1, 1'b0, 4);
    latency_check();
    wait_drain();

    // BLK=16 instance
    @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    send_tile(16, SIZE_16, 0, 1, 1'b0, 16);
    latency_check();
    wait_drain();
    stream3(16);

    check_eq("queue_empty", BW'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
